// File: rtl/seq_subtractor_18.sv
// Multi-cycle subtractor: diff = a - b computed SLICE bits per clock, LSB first,
// with the inter-slice borrow carried in a register. Start/done handshake.
module seq_subtractor_18 #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned SLICE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned NSLICE = WIDTH / SLICE;
  localparam int unsigned IDXW   = $clog2(NSLICE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] partial;
  logic             borrow;

  logic [SLICE:0]   slice_res;
  logic [SLICE-1:0] d;
  logic             bout;
  logic [WIDTH-1:0] full;
  logic             last;

  // The top bit of the (SLICE+1)-bit result is set exactly when the slice
  // subtraction goes negative, i.e. it is the outgoing borrow.
  always_comb begin
    slice_res = {1'b0, a_r[idx*SLICE +: SLICE]}
              - {1'b0, b_r[idx*SLICE +: SLICE]}
              - {{SLICE{1'b0}}, borrow};
    d    = slice_res[SLICE-1:0];
    bout = slice_res[SLICE];
    full = partial;
    full[idx*SLICE +: SLICE] = d;
    last = (idx == IDXW'(NSLICE - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      a_r        <= '0;
      b_r        <= '0;
      partial    <= '0;
      borrow     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_r    <= a;
            b_r    <= b;
            borrow <= 1'b0;
            idx    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          partial[idx*SLICE +: SLICE] <= d;
          borrow <= bout;
          idx    <= idx + 1'b1;
          // Results come from the bypassed partial so the final slice is included.
          if (last) begin
            diff       <= full;
            borrow_out <= bout;
            zero       <= (full == '0);
            overflow   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (full[WIDTH-1] != a_r[WIDTH-1]);
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_subtractor_18.sv
// Directed self-checking bench for seq_subtractor_18: latency, flags, back-to-back,
// ignored start during RUN and reset abort.
module tb_seq_subtractor_18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [17:0] a_i = '0;
  logic [17:0] b_i = '0;
  logic        busy, done, borrow_out, zero, overflow;
  logic [17:0] diff;

  int n_cmp = 0;
  int n_err = 0;

  seq_subtractor_18 #(.WIDTH(18), .SLICE(2)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a_i), .b(b_i),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Leaves the bench at the falling edge just after the start-sampling edge.
  task automatic launch(input logic [17:0] av, input logic [17:0] bv);
    @(negedge clk);
    a_i = av; b_i = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Counts falling edges until done is seen (bounded); also counts busy cycles.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0; busy_cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cyc++;
    end while (!done && cyc < 40);
  endtask

  task automatic check_result(input string tag, input logic [17:0] d, input logic bo,
                              input logic z, input logic ov);
    chk({tag, ".diff"}, 32'(diff), 32'(d));
    chk({tag, ".borrow"}, 32'(borrow_out), 32'(bo));
    chk({tag, ".zero"}, 32'(zero), 32'(z));
    chk({tag, ".ovf"}, 32'(overflow), 32'(ov));
  endtask

  initial begin
    int cyc, bc, dn, first;

    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    check_result("rst", 18'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 5 - 3: busy at first falling edge plus 8 more, done 9 clocks after start edge
    launch(18'd5, 18'd3);
    chk("t1.busy_e0", 32'(busy), 1);
    wait_done(cyc, bc);
    chk("t1.latency", 32'(cyc), 9);
    chk("t1.busy_cycles", 32'(bc), 8);
    chk("t1.busy_at_done", 32'(busy), 0);
    check_result("t1", 18'd2, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1.done_pulse", 32'(done), 0);

    // 0 - 1: borrow ripples through every slice
    launch(18'd0, 18'd1);
    wait_done(cyc, bc);
    chk("t2.latency", 32'(cyc), 9);
    check_result("t2", 18'h3FFFF, 1'b1, 1'b0, 1'b0);

    // Most negative minus one
    launch(18'h20000, 18'd1);
    wait_done(cyc, bc);
    check_result("t3a", 18'h1FFFF, 1'b0, 1'b0, 1'b1);

    // Most positive minus (-1)
    launch(18'h1FFFF, 18'h3FFFF);
    wait_done(cyc, bc);
    check_result("t3b", 18'h20000, 1'b1, 1'b0, 1'b1);

    // Equal operands; operands change and start pulses mid-run
    launch(18'h12345, 18'h12345);
    dn = 0; first = 0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 3) begin a_i = 18'h3FFFF; b_i = 18'h3FFFF; start = 1'b1; end
      if (k == 4) start = 1'b0;
      if (done) begin
        dn++;
        if (first == 0) first = k;
      end
    end
    chk("t4.done_count", 32'(dn), 1);
    chk("t4.latency", 32'(first), 9);
    check_result("t4", 18'h0, 1'b0, 1'b1, 1'b0);

    // Back-to-back: start held high, operands swapped on the done cycle
    @(negedge clk);
    a_i = 18'd10; b_i = 18'd4; start = 1'b1;
    @(negedge clk);
    wait_done(cyc, bc);
    chk("t5a.latency", 32'(cyc), 9);
    check_result("t5a", 18'd6, 1'b0, 1'b0, 1'b0);
    a_i = 18'd4; b_i = 18'd10;
    @(negedge clk);
    chk("t5.restart_busy", 32'(busy), 1);
    start = 1'b0;
    wait_done(cyc, bc);
    chk("t5b.spacing", 32'(cyc + 1), 10);
    check_result("t5b", 18'h3FFFA, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    chk("t5.hold_done", 32'(done), 0);
    chk("t5.hold_diff", 32'(diff), 32'h3FFFA);

    // Reset asserted at RUN edge E4 aborts without done
    launch(18'd7, 18'd2);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6.busy", 32'(busy), 0);
    chk("t6.done", 32'(done), 0);
    check_result("t6", 18'h0, 1'b0, 1'b0, 1'b0);
    dn = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk("t6.no_done", 32'(dn), 0);

    launch(18'd7, 18'd2);
    wait_done(cyc, bc);
    chk("t7.latency", 32'(cyc), 9);
    check_result("t7", 18'd5, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_subtractor_18.md
Name: seq_subtractor_18

Overview:
- Multi-cycle 18-bit subtractor; the inverse operation of the datapath ripple adder.
- Computes diff = a - b two bits per clock, LSB slice first, with the borrow rippling between slices through a register.
- Sits beside the adder in the ALU path. Serves SUB/CMP instructions via a start/done handshake.
- Produces difference plus borrow, zero and signed-overflow flags.

Parameters:
- WIDTH, 18, operand and result width in bits.
- SLICE, 2, bits processed per cycle. WIDTH must be divisible by SLICE; NSLICE = WIDTH/SLICE = 9.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  minuend, unsigned or two's complement.
- b  input  WIDTH  subtrahend.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse; result outputs updated on the same edge.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow_out  output  1  1 iff a < b, unsigned.
- zero  output  1  1 iff diff == 0.
- overflow  output  1  signed overflow: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]).

Behaviour:
- Reset is synchronous, active-high, one clock cycle.
  - Clears state to IDLE and slice index to 0.
  - Clears the operand, partial-difference and borrow registers.
  - Clears busy=0, done=0, diff=0, borrow_out=0, zero=0, overflow=0.
- States:
  - IDLE: busy=0, done=0.
  - RUN: busy=1, done=0.
  - DONE: busy=0, done=1, lasts exactly one cycle.
- Clock-edge E0: start=1 in IDLE or DONE.
  - Latch a and b into internal registers.
  - Internal borrow := 0, idx := 0, state := RUN.
- Operand ports are ignored after E0; changes during RUN have no effect.
- Edges E1..E9, in RUN, processing slice idx:
  - {bout, d} = a_r[idx*2+1:idx*2] - b_r[idx*2+1:idx*2] - borrow.
  - Write d into partial[idx*2+1:idx*2]; borrow := bout; idx := idx+1.
- E9, last slice (idx == NSLICE-1):
  - Load diff with the full partial result, including the slice written on this edge.
  - Load borrow_out with the final borrow, and zero and overflow from that full result.
  - state := DONE.
- Latency: done is high in the cycle following E9, i.e. 9 clocks after the start-sampling edge.
- E10:
  - If start=1, accept a new operation (back-to-back, state := RUN).
  - Otherwise state := IDLE.
  - Throughput: one result per 10 cycles.
- start while busy=1 is ignored: no restart and no queuing.
- diff and flags hold their last values until the next completion edge. They are never updated mid-operation.
- rst asserted during RUN:
  - Aborts immediately; no done pulse.
  - Outputs go to their reset values.
  - The next start after rst is released is served normally.
- rst and start in the same cycle: rst wins and start is dropped.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
- a=5, b=3, start pulsed one cycle -> busy high 9 cycles; done pulse 9 clocks after the start edge; diff=2, borrow_out=0, zero=0, overflow=0.
- a=0, b=1 -> diff=0x3FFFF, borrow_out=1, zero=0, overflow=0. Checks borrow ripple through all 9 slices.
- a=0x20000 (most negative), b=1 -> diff=0x1FFFF, borrow_out=0, overflow=1; then a=0x1FFFF, b=0x3FFFF -> diff=0x20000, overflow=1, borrow_out=1.
- a=b=0x12345 -> diff=0, zero=1, borrow_out=0. During RUN, drive a=b=0x3FFFF and pulse start -> result unchanged, done still at cycle 9, exactly one done pulse.
- Back-to-back: hold start=1 with a=10, b=4, then a=4, b=10 on the done cycle -> two done pulses 10 cycles apart; diff=6 then 0x3FFFA with borrow_out=1.
- Start a=7, b=2; assert rst for one cycle at RUN edge E4 -> all outputs 0, no done. Restart a=7, b=2 -> diff=5, done 9 clocks after the new start edge.
